// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit with ready-based data bus
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               request strobe, sampled only while idle
//   mem_read            load request
//   mem_write[3:0]      store byte mask (0001 byte, 0011 half, 1111 word)
//   read_size[1:0]      load size (0 byte, 1 half, 2 word, 3 illegal)
//   read_signed         sign-extend byte/half loads
//   addr, store_data    effective byte address and rs2 value
//   busy                pipeline stall, high from the cycle after accept through done
//   done, misaligned    one-cycle completion pulse and error flag
//   load_data           extended load result, held until the next successful load
//   bus_*               data-memory bus (word-aligned address, lane strobes/data)
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_read,
  input  logic [3:0]        mem_write,
  input  logic [1:0]        read_size,
  input  logic              read_signed,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [31:0]       load_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FIN
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t     state;

  // Attributes of the in-flight request, needed to extract the load result
  logic       lat_load;
  logic [1:0] lat_size;
  logic       lat_signed;
  logic [1:0] lat_lo;

  // Request classification from the raw inputs (only meaningful in IDLE)
  logic       is_store;
  logic       is_load;
  logic [1:0] req_size;
  logic       req_err;

  always_comb begin
    is_store = (mem_write != 4'b0000);
    is_load  = !is_store && mem_read;
    req_size = SZ_WORD;
    req_err  = 1'b0;
    if (is_store) begin
      case (mem_write)
        4'b0001: req_size = SZ_BYTE;
        4'b0011: req_size = SZ_HALF;
        4'b1111: req_size = SZ_WORD;
        default: req_err  = 1'b1;
      endcase
    end else if (is_load) begin
      req_size = read_size;
      if (read_size == 2'd3) begin
        req_err = 1'b1;
      end
    end
    if (is_store || is_load) begin
      if (req_size == SZ_HALF && addr[0]) begin
        req_err = 1'b1;
      end
      if (req_size == SZ_WORD && addr[1:0] != 2'b00) begin
        req_err = 1'b1;
      end
    end
  end

  // Store lane placement: strobes shifted to the addressed lane, data
  // replicated so that whichever lane is strobed carries the right bytes.
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;

  always_comb begin
    wstrb_n = 4'b1111;
    wdata_n = store_data;
    case (req_size)
      SZ_BYTE: begin
        wstrb_n = 4'b0001 << addr[1:0];
        wdata_n = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        wstrb_n = 4'b0011 << {addr[1], 1'b0};
        wdata_n = {2{store_data[15:0]}};
      end
      default: begin
        wstrb_n = 4'b1111;
        wdata_n = store_data;
      end
    endcase
  end

  // Load extraction and extension from the returned word
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ext_data;

  always_comb begin
    rd_byte  = bus_rdata[{lat_lo, 3'b000} +: 8];
    rd_half  = bus_rdata[{lat_lo[1], 4'b0000} +: 16];
    ext_data = bus_rdata;
    case (lat_size)
      SZ_BYTE: ext_data = {{24{lat_signed & rd_byte[7]}}, rd_byte};
      SZ_HALF: ext_data = {{16{lat_signed & rd_half[15]}}, rd_half};
      default: ext_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_load   <= 1'b0;
      lat_size   <= 2'd0;
      lat_signed <= 1'b0;
      lat_lo     <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      load_data  <= 32'd0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wstrb  <= 4'b0000;
      bus_wdata  <= 32'd0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            lat_load   <= is_load;
            lat_size   <= req_size;
            lat_signed <= read_signed;
            lat_lo     <= addr[1:0];
            if (req_err || !(is_store || is_load)) begin
              // Errors and no-ops complete without touching the bus
              state      <= FIN;
              done       <= 1'b1;
              misaligned <= req_err;
            end else begin
              state     <= REQ;
              bus_req   <= 1'b1;
              bus_we    <= is_store;
              bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus_wstrb <= is_store ? wstrb_n : 4'b0000;
              bus_wdata <= is_store ? wdata_n : 32'd0;
            end
          end
        end
        REQ: begin
          if (bus_ready) begin
            state   <= FIN;
            bus_req <= 1'b0;
            done    <= 1'b1;
            if (lat_load) begin
              load_data <= ext_data;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
